// File: rtl/game_pkg.sv
// Shared encodings for the game datapath: sequencer states, direction codes and ON/OFF levels.
package game_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_REG   = 3'd2,
    S_APPLY = 3'd3,
    S_DMAP  = 3'd4,
    S_DLINK = 3'd5
  } state_t;

  localparam logic [2:0] NO_ACTION = 3'd0;
  localparam logic [2:0] ATTACK    = 3'd1;
  localparam logic [2:0] UP        = 3'd2;
  localparam logic [2:0] DOWN      = 3'd3;
  localparam logic [2:0] LEFT      = 3'd4;
  localparam logic [2:0] RIGHT     = 3'd5;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  function automatic logic is_draw(input state_t s);
    return (s == S_DMAP) || (s == S_DLINK);
  endfunction

endpackage

// File: rtl/game_control_frame_ticker.sv
// Frame pacing counter: counts FRAME_CYCLES-1 down to 0 and emits a registered one-cycle tick per frame.
module frame_ticker
  import game_pkg::*;
#(
  parameter int FRAME_CYCLES = 833334,
  parameter int CNT_W        = 20
) (
  input  logic clock,
  input  logic resetn,
  input  logic run,
  output logic tick
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count_reg;
  logic             tick_reg;

  // While not running the counter parks at the reload value so a new game starts on a full frame.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      count_reg <= RELOAD;
      tick_reg  <= OFF;
    end else if (!run) begin
      count_reg <= RELOAD;
      tick_reg  <= OFF;
    end else begin
      tick_reg  <= (count_reg == '0);
      count_reg <= (count_reg == '0) ? RELOAD : count_reg - 1'b1;
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/game_control.sv
// Per-frame sequencer for the character, map and collision responders.
// Optional draw-phase watchdog enabled by defining GAME_CONTROL_TIMEOUT_EN.
module game_control
  import game_pkg::*;
#(
  parameter int FRAME_CYCLES = 833334,
  parameter int CNT_W        = 20
`ifdef GAME_CONTROL_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       start,
  input  logic       map_draw_done,
  input  logic       link_draw_done,
  output logic       init,
  output logic       idle,
  output logic       reg_action,
  output logic       apply_action,
  output logic       draw_map,
  output logic       draw_link,
  output logic       frame_overrun,
  output logic [7:0] overrun_count
`ifdef GAME_CONTROL_TIMEOUT_EN
  ,
  output logic       draw_timeout
`endif
);

  state_t     state_reg, state_next;
  logic       first_cycle_reg;
  logic       tick_pending_reg;
  logic       frame_overrun_reg;
  logic [7:0] overrun_count_reg;
  logic       tick;
  logic       overrun_evt;
  logic       timeout_hit;

  frame_ticker #(
    .FRAME_CYCLES(FRAME_CYCLES),
    .CNT_W       (CNT_W)
  ) u_ticker (
    .clock (clock),
    .resetn(resetn),
    .run   (state_reg != S_INIT),
    .tick  (tick)
  );

  // A tick is missed when the loop is busy, or when one frame is already queued.
  assign overrun_evt = tick && ((state_reg != S_IDLE) || tick_pending_reg);

`ifdef GAME_CONTROL_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES) + 1 > 12) ? $clog2(TIMEOUT_CYCLES) + 1 : 12;

  logic [WD_W-1:0] wd_reg;
  logic            draw_timeout_reg;

  assign timeout_hit = is_draw(state_reg) && (wd_reg == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (!resetn) begin
      wd_reg           <= '0;
      draw_timeout_reg <= OFF;
    end else begin
      if (state_next != state_reg)
        wd_reg <= '0;
      else if (is_draw(state_reg))
        wd_reg <= wd_reg + 1'b1;
      if (timeout_hit)
        draw_timeout_reg <= ON;
    end
  end

  assign draw_timeout = draw_timeout_reg;
`else
  assign timeout_hit = OFF;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_INIT:  if (start) state_next = S_IDLE;
      S_IDLE:  if (tick || tick_pending_reg) state_next = S_REG;
      S_REG:   state_next = S_APPLY;
      S_APPLY: state_next = S_DMAP;
      // Done flags may still be high from the previous phase during the first cycle.
      S_DMAP:  if (map_draw_done && !first_cycle_reg) state_next = S_DLINK;
      S_DLINK: if (link_draw_done && !first_cycle_reg) state_next = S_IDLE;
      default: state_next = S_INIT;
    endcase
    if (timeout_hit)
      state_next = S_IDLE;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_reg         <= S_INIT;
      first_cycle_reg   <= OFF;
      tick_pending_reg  <= OFF;
      frame_overrun_reg <= OFF;
      overrun_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      first_cycle_reg <= is_draw(state_next) && (state_next != state_reg);
      if (overrun_evt)
        tick_pending_reg <= ON;
      else if (state_reg == S_IDLE && state_next == S_REG)
        tick_pending_reg <= OFF;
      if (overrun_evt) begin
        frame_overrun_reg <= ON;
        if (overrun_count_reg != 8'hFF)
          overrun_count_reg <= overrun_count_reg + 8'd1;
      end
    end
  end

  always_comb begin
    init         = OFF;
    idle         = OFF;
    reg_action   = OFF;
    apply_action = OFF;
    draw_map     = OFF;
    draw_link    = OFF;
    case (state_reg)
      S_INIT:  init         = ON;
      S_IDLE:  idle         = ON;
      S_REG:   reg_action   = ON;
      S_APPLY: apply_action = ON;
      S_DMAP:  draw_map     = ON;
      S_DLINK: draw_link    = ON;
      default: init         = ON;
    endcase
  end

  assign frame_overrun = frame_overrun_reg;
  assign overrun_count = overrun_count_reg;

endmodule

// File: tb/tb_game_control.sv
// Directed bench for game_control with FRAME_CYCLES = 64; covers GAME_CONTROL_TIMEOUT_EN when defined.
module tb_game_control;

  localparam int FC = 64;

  localparam logic [5:0] ST_INIT  = 6'b100000;
  localparam logic [5:0] ST_IDLE  = 6'b010000;
  localparam logic [5:0] ST_REG   = 6'b001000;
  localparam logic [5:0] ST_APPLY = 6'b000100;
  localparam logic [5:0] ST_DMAP  = 6'b000010;
  localparam logic [5:0] ST_DLINK = 6'b000001;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       map_draw_done = 1'b0;
  logic       link_draw_done = 1'b0;
  logic       init, idle, reg_action, apply_action, draw_map, draw_link, frame_overrun;
  logic [7:0] overrun_count;
`ifdef GAME_CONTROL_TIMEOUT_EN
  logic       draw_timeout;
`endif
  logic [5:0] strobe_vec;

  game_control #(
    .FRAME_CYCLES(FC),
    .CNT_W       (8)
`ifdef GAME_CONTROL_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(32)
`endif
  ) dut (
    .clock         (clock),
    .resetn        (resetn),
    .start         (start),
    .map_draw_done (map_draw_done),
    .link_draw_done(link_draw_done),
    .init          (init),
    .idle          (idle),
    .reg_action    (reg_action),
    .apply_action  (apply_action),
    .draw_map      (draw_map),
    .draw_link     (draw_link),
    .frame_overrun (frame_overrun),
    .overrun_count (overrun_count)
`ifdef GAME_CONTROL_TIMEOUT_EN
    ,
    .draw_timeout  (draw_timeout)
`endif
  );

  always #5 clock = ~clock;

  assign strobe_vec = {init, idle, reg_action, apply_action, draw_map, draw_link};

  typedef struct {
    string      name;
    logic [5:0] strobe;
    int         len;
  } vec_t;

  vec_t tbl[15];

  int n_cmp = 0;
  int n_bad = 0;
  int onehot_err = 0;

  // Responder model: done rises after `delay` cycles of strobe, drops one cycle after strobe falls.
  int map_delay = 10, link_delay = 10;
  bit map_never = 0, map_stick = 0, link_force = 0;
  int map_cnt = 0, link_cnt = 0;
  bit map_prev = 0, link_prev = 0, map_q = 0, link_q = 0;

  logic [5:0] rs[8];
  int         rl[8];
  int         nr;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: got %0d", name, act);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    if ($countones(strobe_vec) != 1) onehot_err++;
    if (draw_map) begin
      map_cnt++;
      map_q = !map_never && (map_cnt > map_delay);
      map_prev = 1;
    end else begin
      if (!map_prev) map_q = 0;
      map_prev = 0;
      map_cnt = 0;
    end
    if (draw_link) begin
      link_cnt++;
      link_q = link_cnt > link_delay;
      link_prev = 1;
    end else begin
      if (!link_prev) link_q = 0;
      link_prev = 0;
      link_cnt = 0;
    end
    map_draw_done  = map_q | (map_stick & map_draw_done);
    link_draw_done = link_q | link_force;
  endtask

  task automatic wait_reg(output int n);
    n = 0;
    while (!reg_action && n < 300) begin
      cyc();
      n++;
    end
  endtask

  // Starting on a reg_action sample, collect phase runs until the next reg_action.
  task automatic record_frame();
    logic [5:0] cur;
    int len, guard;
    bit done;
    nr = 0; cur = strobe_vec; len = 1; guard = 0; done = 0;
    while (!done && guard < 500) begin
      cyc();
      guard++;
      if (strobe_vec == cur) len++;
      else begin
        if (nr < 8) begin
          rs[nr] = cur;
          rl[nr] = len;
        end
        nr++;
        if (reg_action) done = 1;
        cur = strobe_vec;
        len = 1;
      end
    end
    check("frame completed within bound", int'(done), 1);
  endtask

  task automatic check_frame(input int f);
    check($sformatf("frame%0d run count", f + 1), nr, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < nr) begin
        check($sformatf("%s strobe", tbl[f*5+i].name), int'(rs[i]), int'(tbl[f*5+i].strobe));
        check($sformatf("%s length", tbl[f*5+i].name), rl[i], tbl[f*5+i].len);
      end
    end
  endtask

  initial begin
    int n;
    int k;
    tbl[0]  = '{"f1 reg",    ST_REG,   1};
    tbl[1]  = '{"f1 apply",  ST_APPLY, 1};
    tbl[2]  = '{"f1 dmap",   ST_DMAP,  11};
    tbl[3]  = '{"f1 dlink",  ST_DLINK, 11};
    tbl[4]  = '{"f1 idle",   ST_IDLE,  40};
    tbl[5]  = '{"f2 reg",    ST_REG,   1};
    tbl[6]  = '{"f2 apply",  ST_APPLY, 1};
    tbl[7]  = '{"f2 dmap",   ST_DMAP,  4};
    tbl[8]  = '{"f2 dlink",  ST_DLINK, 2};
    tbl[9]  = '{"f2 idle",   ST_IDLE,  56};
    tbl[10] = '{"f3 reg",    ST_REG,   1};
    tbl[11] = '{"f3 apply",  ST_APPLY, 1};
    tbl[12] = '{"f3 dmap",   ST_DMAP,  11};
    tbl[13] = '{"f3 dlink",  ST_DLINK, 81};
    tbl[14] = '{"f3 idle",   ST_IDLE,  1};

    // Reset and start
    resetn = 0;
    repeat (3) cyc();
    check("reset strobes", int'(strobe_vec), int'(ST_INIT));
    check("reset overrun_count", int'(overrun_count), 0);
    check("reset frame_overrun", int'(frame_overrun), 0);
`ifdef GAME_CONTROL_TIMEOUT_EN
    check("reset draw_timeout", int'(draw_timeout), 0);
`endif
    resetn = 1;
    cyc();
    check("init held without start", int'(strobe_vec), int'(ST_INIT));
    start = 1;
    cyc();
    check("idle after start", int'(strobe_vec), int'(ST_IDLE));
    wait_reg(n);
    check("first reg_action latency", n, 65);

    // Nominal frame
    record_frame();
    check_frame(0);
    check("nominal frame_overrun", int'(frame_overrun), 0);

    // Stale done flags on draw-state entry
    map_delay = 3; map_stick = 1; link_force = 1;
    link_draw_done = 1;
    record_frame();
    check_frame(1);
    check("stale frame_overrun", int'(frame_overrun), 0);

    // Overrun: character drawer answers late
    map_stick = 0; link_force = 0; map_delay = 10; link_delay = 80;
    record_frame();
    check_frame(2);
    check("overrun frame_overrun", int'(frame_overrun), 1);
    check("overrun overrun_count", int'(overrun_count), 1);

    map_never = 1;
`ifdef GAME_CONTROL_TIMEOUT_EN
    k = 0;
    while (!draw_map && k < 100) begin cyc(); k++; end
    n = 0;
    while (draw_map && n < 200) begin cyc(); n++; end
    check("timeout draw_map length", n, 32);
    check("timeout idle", int'(idle), 1);
    check("timeout draw_timeout", int'(draw_timeout), 1);
`else
    // Saturation while the map drawer never finishes
    repeat (640) cyc();
    check("overrun_count after 10 more ticks", int'(overrun_count), 11);
    repeat (300 * FC - 640) cyc();
    check("saturated overrun_count", int'(overrun_count), 255);
    check("saturated frame_overrun", int'(frame_overrun), 1);
    check("still in draw_map", int'(draw_map), 1);
`endif

    // Reset in the middle of the map draw phase
    k = 0;
    while (!draw_map && k < 200) begin cyc(); k++; end
    check("in draw_map before reset", int'(draw_map), 1);
    resetn = 0;
    cyc();
    check("mid-draw reset strobes", int'(strobe_vec), int'(ST_INIT));
    check("mid-draw reset overrun_count", int'(overrun_count), 0);
    check("mid-draw reset frame_overrun", int'(frame_overrun), 0);
`ifdef GAME_CONTROL_TIMEOUT_EN
    check("mid-draw reset draw_timeout", int'(draw_timeout), 0);
`endif
    resetn = 1;
    cyc();
    check("idle after restart", int'(strobe_vec), int'(ST_IDLE));
    wait_reg(n);
    check("restart reg_action latency", n, 65);

    check("one-hot strobe violations", onehot_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_control.md
Name: game_control

Overview:
- Per-frame sequencer (initiator) that drives the character, map and collision responders.
- Issues the one-hot phase strobes `init`, `idle`, `reg_action`, `apply_action`, `draw_map`, `draw_link`.
- Waits on the responders' completion flags and paces the whole loop from an internal frame-tick counter.
- Sits between the top level (`KEY`/`SW` start) and the character, map-draw and collision blocks.

Parameters:
- `FRAME_CYCLES`, 833334, clock cycles per game frame (60 Hz at 50 MHz); minimum 16.
- `CNT_W`, 20, width of the frame counter; must satisfy 2^`CNT_W` >= `FRAME_CYCLES`.
- `TIMEOUT_CYCLES`, 4096, watchdog limit per draw phase (used only with the optional feature).

Ports:
- `clock`  in  1  system clock.
- `resetn`  in  1  synchronous reset, active-low.
- `start`  in  1  level; leaves `S_INIT` when high.
- `map_draw_done`  in  1  map drawer finished; level, may stay high until `draw_map` drops.
- `link_draw_done`  in  1  character drawer finished; same semantics as `map_draw_done`.
- `init`  out  1  high while in `S_INIT`.
- `idle`  out  1  high while in `S_IDLE`.
- `reg_action`  out  1  one-cycle strobe: latch user command.
- `apply_action`  out  1  one-cycle strobe: move using current collision.
- `draw_map`  out  1  high for the whole map draw phase.
- `draw_link`  out  1  high for the whole character draw phase.
- `frame_overrun`  out  1  sticky; set when a tick arrives outside `S_IDLE`.
- `overrun_count`  out  8  saturating count of missed ticks.

Behaviour:
- Clocking and reset: one clock. Reset is synchronous, active-low (`resetn`), sampled on the rising edge of `clock`.
- Reset values: state = `S_INIT`, so `init` = 1 and all other strobes 0. Frame counter = `FRAME_CYCLES`-1. `tick_pending` = 0, `frame_overrun` = 0, `overrun_count` = 0.
- Reset mid-phase: abandons the phase immediately; the next cycle shows the reset values.
- States: `S_INIT`, `S_IDLE`, `S_REG`, `S_APPLY`, `S_DMAP`, `S_DLINK`. Outputs are a Moore decode of state; exactly one phase strobe is high in any cycle.
- `S_INIT` -> `S_IDLE` when `start` = 1.
- `S_IDLE` -> `S_REG` when `tick` = 1 or `tick_pending` = 1. Entering `S_REG` clears `tick_pending`.
- `S_REG` -> `S_APPLY` unconditionally (1 cycle). `collision` is combinational off position and direction, so it is valid in `S_APPLY`.
- `S_APPLY` -> `S_DMAP` unconditionally (1 cycle).
- `S_DMAP` -> `S_DLINK` when `map_draw_done` = 1 and the state age is >= 1.
- `S_DLINK` -> `S_IDLE` when `link_draw_done` = 1 and the state age is >= 1.
- Stale-done guard: done inputs are ignored in the first cycle of each draw state, because responders clear done only after their draw strobe falls.
- State age: a 1-bit `first_cycle` flag, set on entry to a draw state.
- Frame counter: free-running down-counter; `tick` = (counter == 0), then reload to `FRAME_CYCLES`-1. It runs in all states except `S_INIT`, where it holds at the reload value.
- Tick while not in `S_IDLE` (and not `S_INIT`): set `tick_pending`, set `frame_overrun`, increment `overrun_count`, saturating at 255.
- Tick while `tick_pending` is already 1: still counts as an overrun; `tick_pending` stays 1 (no queueing beyond one).
- Simultaneous tick and `S_DLINK` -> `S_IDLE`: counts as an overrun, sets pending, and the next frame starts one cycle later from `S_IDLE`.
- Latency: a tick seen in `S_IDLE` gives `reg_action` high on the next cycle.

Optional Feature:
- Macro: `GAME_CONTROL_TIMEOUT_EN`.
- Defined: a 12-bit-or-wider watchdog counts cycles in `S_DMAP`/`S_DLINK`.
  - On reaching `TIMEOUT_CYCLES` the FSM forces a transition to `S_IDLE`.
  - Sets an extra sticky output `draw_timeout` (1 bit, reset 0).
  - The watchdog clears on each draw-state entry.
- Undefined: no watchdog and no `draw_timeout` port; draw states wait indefinitely.

Decomposition:
- Shared package `game_pkg`:
  - state encoding constants `S_INIT`..`S_DLINK`;
  - the direction codes `NO_ACTION`, `ATTACK`, `UP`, `DOWN`, `LEFT`, `RIGHT` (3-bit) shared with the character and collision blocks;
  - `ON`/`OFF`.
- Natural sub-module: `frame_ticker`, holding the counter plus the tick output, parameterised by `FRAME_CYCLES`/`CNT_W`.

Test Plan (`FRAME_CYCLES` = 64):
- Reset and start:
  - `resetn` = 0 for 3 cycles -> `init` = 1, `overrun_count` = 0.
  - `start` = 1 -> `idle` = 1 next cycle.
  - First `reg_action` 65 cycles after `idle` rises.
- Nominal frame: done responders answer 10 cycles after their draw strobe rises, and drop done 1 cycle after the strobe falls.
  - Expect the sequence `reg_action`(1), `apply_action`(1), `draw_map`(11), `draw_link`(11), then `idle`.
  - `frame_overrun` = 0.
- Stale done: hold `map_draw_done` = 1 entering `S_DLINK`, and `link_draw_done` = 1 already on `S_DLINK` entry.
  - `draw_link` lasts >= 2 cycles; no skip.
- Overrun: `link_draw_done` delayed 80 cycles.
  - `frame_overrun` = 1 and `overrun_count` = 1.
  - `reg_action` 1 cycle after return to `S_IDLE`.
- Saturation: hold `map_draw_done` = 0 for 300×64 cycles -> `overrun_count` = 255, no wrap.
- Reset mid-draw: `resetn` = 0 during `draw_map` -> next cycle `init` = 1, `draw_map` = 0, counters cleared.
- With `GAME_CONTROL_TIMEOUT_EN` (`TIMEOUT_CYCLES` = 32): never assert `map_draw_done` -> after 32 cycles `idle` = 1 and `draw_timeout` = 1.
